mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LATENCY, default 1: BRAM read latency in cycles; legal values 1 or 2.
REQ-002 Parameter STARVE_LIMIT, default 8: consecutive denied fetch cycles before fetch is promoted.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 f_req / f_addr / f_gnt  in/in/out  1/32/1  fetch read port (fetch never writes).
REQ-006 f_rvalid / f_rdata  out/out  1/32  fetch read response.
REQ-007 c_flush  input  1  pipeline flush; discards in-flight fetch responses.
REQ-008 d_req / d_we / d_addr / d_wdata / d_gnt  in/in/in/in/out  1/1/32/32/1  load-store port.
REQ-009 d_rvalid / d_rdata  out/out  1/32  load-store read response.
REQ-010 g_req / g_we / g_addr / g_wdata / g_gnt  in/in/in/in/out  1/1/32/32/1  online-debug port.
REQ-011 g_rvalid / g_rdata  out/out  1/32  debug read response.
REQ-012 g_halt  input  1  debug halt; blocks fetch grants while high.
REQ-013 m_en / m_we / m_addr / m_wdata  out/out/out/out  1/1/30/32  single BRAM port; m_addr = granted addr[31:2].
REQ-014 m_rdata  input  32  BRAM read data, valid LATENCY cycles after m_en with m_we=0.

Function
REQ-015 At most one of f_gnt, d_gnt, g_gnt SHALL be high in any cycle; grant is combinational from current requests and registered state.
REQ-016 Default priority SHALL be debug > load-store > fetch.
REQ-017 Fetch SHALL NOT be granted while g_halt=1, regardless of starvation state.
REQ-018 starve_cnt (4 bits, saturating) SHALL increment each cycle f_req=1, g_halt=0 and f_gnt=0; it SHALL clear on f_gnt or f_req=0.
REQ-019 When starve_cnt >= STARVE_LIMIT, fetch SHALL outrank load-store (debug still wins) for exactly one grant.
REQ-020 In a granted cycle m_en=1 and m_we/m_addr/m_wdata SHALL come from the winner; otherwise m_en=0, m_we=0.
REQ-021 A port SHALL treat a request as accepted only in a cycle where its gnt=1; request fields need only be stable in that cycle.
REQ-022 For each granted read, a LATENCY-deep owner pipeline (2-bit id + valid) SHALL route m_rdata to the owner: rvalid high exactly LATENCY cycles after the grant, for one cycle.
REQ-023 Granted writes SHALL produce no rvalid.
REQ-024 Back-to-back grants to any mix of ports SHALL sustain one access per cycle; responses return in grant order.
REQ-025 c_flush=1 SHALL kill every fetch entry in the owner pipeline, including one granted that same cycle; killed entries never raise f_rvalid.
REQ-026 c_flush SHALL NOT affect load-store or debug entries, or grants to them.
REQ-027 f_rdata/d_rdata/g_rdata SHALL equal m_rdata directly; their value is don't-care when the matching rvalid=0.

Reset
REQ-028 While rst=1: all gnt=0, m_en=0, m_we=0, all rvalid=0, starve_cnt=0, owner pipeline cleared.
REQ-029 Reads in flight when rst asserts SHALL never produce rvalid after reset.
REQ-030 First grant possible in the first cycle with rst=0.

Verification
REQ-031 f_req=1 only, f_addr=0x0000_0010, LATENCY=1 -> f_gnt same cycle, m_addr=0x4, f_rvalid next cycle with f_rdata=mem[4].
REQ-032 g_req, d_req and f_req all high for 12 cycles -> g_gnt every cycle, d_gnt/f_gnt never; g_req then low with d_req high -> f_gnt once 8 denied cycles have elapsed, d_gnt otherwise.
REQ-033 d_req=1, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, then read of 0x20 -> no d_rvalid for the write; read returns 0xDEADBEEF.
REQ-034 Fetch reads granted in cycles N and N+1, c_flush=1 in N+1, LATENCY=2 -> no f_rvalid in N+2 or N+3.
REQ-035 g_halt=1 with f_req=1 for 20 cycles -> f_gnt=0 throughout, starve_cnt stays 0; g_halt falls -> f_gnt next cycle.
REQ-036 rst=1 in the cycle after a read grant -> no rvalid in the following two cycles; all outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter shared by fetch, load-store and online-debug masters.
// Fixed priority debug > load-store > fetch, with starvation promotion for fetch and read-response routing.
module mem_port_arbiter #(
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        c_flush,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  input  logic        g_req,
  input  logic        g_we,
  input  logic [31:0] g_addr,
  input  logic [31:0] g_wdata,
  output logic        g_gnt,
  output logic        g_rvalid,
  output logic [31:0] g_rdata,
  input  logic        g_halt,
  output logic        m_en,
  output logic        m_we,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic [3:0]  dbg_starve_cnt
);

  localparam logic [1:0] ID_F  = 2'd0;
  localparam logic [1:0] ID_D  = 2'd1;
  localparam logic [1:0] ID_G  = 2'd2;
  localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

  logic [3:0]         r_starve_cnt;
  logic [LATENCY-1:0] r_pv;
  logic [1:0]         r_pid [LATENCY];

  logic       w_f_ok;
  logic       w_promote;
  logic       w_rd;
  logic [1:0] w_id;
  logic       w_out_v;
  logic [1:0] w_out_id;
  logic       w_unused;

  assign w_f_ok    = f_req & ~g_halt;
  assign w_promote = ({1'b0, r_starve_cnt} >= LIMIT);

  // Valid/ready contract: a request is accepted only in a cycle where its gnt is high; fields need only be stable then.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    g_gnt = 1'b0;
    if (!rst) begin
      if (g_req)                   g_gnt = 1'b1;
      else if (w_f_ok && w_promote) f_gnt = 1'b1;
      else if (d_req)              d_gnt = 1'b1;
      else if (w_f_ok)             f_gnt = 1'b1;
    end
  end

  always_comb begin
    m_en    = f_gnt | d_gnt | g_gnt;
    m_we    = 1'b0;
    m_addr  = 30'd0;
    m_wdata = 32'd0;
    w_id    = ID_F;
    if (g_gnt) begin
      m_we    = g_we;
      m_addr  = g_addr[31:2];
      m_wdata = g_wdata;
      w_id    = ID_G;
    end else if (d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr[31:2];
      m_wdata = d_wdata;
      w_id    = ID_D;
    end else if (f_gnt) begin
      m_addr  = f_addr[31:2];
    end
  end

  assign w_rd = m_en & ~m_we;

  // Owner pipeline: a flush strips fetch entries at every stage, including the one entering now.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
    end else begin
      r_pv[0] <= w_rd & ~(c_flush & (w_id == ID_F));
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1] & ~(c_flush & (r_pid[i-1] == ID_F));
      end
    end
  end

  always_ff @(posedge clk) begin
    r_pid[0] <= w_id;
    for (int i = 1; i < LATENCY; i++) begin
      r_pid[i] <= r_pid[i-1];
    end
  end

  assign w_out_v  = r_pv[LATENCY-1] & ~rst;
  assign w_out_id = r_pid[LATENCY-1];

  // A fetch response arriving in a flush cycle is discarded as well.
  assign f_rvalid = w_out_v & (w_out_id == ID_F) & ~c_flush;
  assign d_rvalid = w_out_v & (w_out_id == ID_D);
  assign g_rvalid = w_out_v & (w_out_id == ID_G);

  assign f_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign g_rdata = m_rdata;

  always_ff @(posedge clk) begin
    if (rst || f_gnt || !f_req) begin
      r_starve_cnt <= 4'd0;
    end else if (!g_halt && (r_starve_cnt != 4'hF)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  assign dbg_starve_cnt = r_starve_cnt;

  assign w_unused = ^{f_addr[1:0], d_addr[1:0], g_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: LATENCY=1 and LATENCY=2 instances share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, c_flush, d_req, d_we, g_req, g_we, g_halt;
  logic [31:0] f_addr, d_addr, d_wdata, g_addr, g_wdata;

  logic [1:0]  f_gnt_v, f_rvalid_v, d_gnt_v, d_rvalid_v, g_gnt_v, g_rvalid_v, m_en_v, m_we_v;
  logic [31:0] f_rdata_a [2];
  logic [31:0] d_rdata_a [2];
  logic [31:0] g_rdata_a [2];
  logic [31:0] m_wdata_a [2];
  logic [31:0] m_rdata_a [2];
  logic [29:0] m_addr_a  [2];
  logic [3:0]  starve_a  [2];

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (i * 32'h0101_0101);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_env
    logic [31:0] mem [16];
    logic [31:0] rd1, rd2;

    initial begin
      for (int i = 0; i < 16; i++) mem[i] = init_word(i);
    end

    // Environment BRAM: read-first, data registered LATENCY times.
    always @(posedge clk) begin
      if (m_en_v[k] && m_we_v[k]) mem[m_addr_a[k][3:0]] <= m_wdata_a[k];
      if (m_en_v[k] && !m_we_v[k]) rd1 <= mem[m_addr_a[k][3:0]];
      rd2 <= rd1;
    end

    assign m_rdata_a[k] = (k == 0) ? rd1 : rd2;

    mem_port_arbiter #(.LATENCY(k + 1), .STARVE_LIMIT(STARVE_LIMIT)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .f_req          (f_req),
      .f_addr         (f_addr),
      .f_gnt          (f_gnt_v[k]),
      .f_rvalid       (f_rvalid_v[k]),
      .f_rdata        (f_rdata_a[k]),
      .c_flush        (c_flush),
      .d_req          (d_req),
      .d_we           (d_we),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .d_gnt          (d_gnt_v[k]),
      .d_rvalid       (d_rvalid_v[k]),
      .d_rdata        (d_rdata_a[k]),
      .g_req          (g_req),
      .g_we           (g_we),
      .g_addr         (g_addr),
      .g_wdata        (g_wdata),
      .g_gnt          (g_gnt_v[k]),
      .g_rvalid       (g_rvalid_v[k]),
      .g_rdata        (g_rdata_a[k]),
      .g_halt         (g_halt),
      .m_en           (m_en_v[k]),
      .m_we           (m_we_v[k]),
      .m_addr         (m_addr_a[k]),
      .m_wdata        (m_wdata_a[k]),
      .m_rdata        (m_rdata_a[k]),
      .dbg_starve_cnt (starve_a[k])
    );
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    int          inst;
    longint      due;
    int          port;   // 0 fetch, 1 load-store, 2 debug
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q [$];
  logic [31:0] model_mem [2][16];
  int          starve_m [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      string       p;
      int          win;   // -1 none, 0 fetch, 1 load-store, 2 debug
      logic        we;
      logic [31:0] addr, wdata;
      logic        got [3];
      logic [31:0] gdat;
      p = (k == 0) ? "L1" : "L2";
      check_eq({p, " starve_cnt"}, 32'(starve_a[k]), 32'(starve_m[k]));
      if (rst) begin
        check_eq({p, " rst f_gnt"}, 32'(f_gnt_v[k]), 0);
        check_eq({p, " rst d_gnt"}, 32'(d_gnt_v[k]), 0);
        check_eq({p, " rst g_gnt"}, 32'(g_gnt_v[k]), 0);
        check_eq({p, " rst m_en"}, 32'(m_en_v[k]), 0);
        check_eq({p, " rst m_we"}, 32'(m_we_v[k]), 0);
        check_eq({p, " rst f_rvalid"}, 32'(f_rvalid_v[k]), 0);
        check_eq({p, " rst d_rvalid"}, 32'(d_rvalid_v[k]), 0);
        check_eq({p, " rst g_rvalid"}, 32'(g_rvalid_v[k]), 0);
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].inst == k) exp_q.delete(i);
        starve_m[k] = 0;
        continue;
      end
      win = -1; we = 1'b0; addr = 32'd0; wdata = 32'd0;
      if (g_req) begin
        win = 2; we = g_we; addr = g_addr; wdata = g_wdata;
      end else if (f_req && !g_halt && starve_m[k] >= STARVE_LIMIT) begin
        win = 0; addr = f_addr;
      end else if (d_req) begin
        win = 1; we = d_we; addr = d_addr; wdata = d_wdata;
      end else if (f_req && !g_halt) begin
        win = 0; addr = f_addr;
      end
      check_eq({p, " f_gnt"}, 32'(f_gnt_v[k]), 32'(win == 0));
      check_eq({p, " d_gnt"}, 32'(d_gnt_v[k]), 32'(win == 1));
      check_eq({p, " g_gnt"}, 32'(g_gnt_v[k]), 32'(win == 2));
      check_eq({p, " m_en"}, 32'(m_en_v[k]), 32'(win >= 0));
      check_eq({p, " m_we"}, 32'(m_we_v[k]), 32'(we));
      if (win >= 0) begin
        check_eq({p, " m_addr"}, 32'(m_addr_a[k]), {2'b00, addr[31:2]});
        if (we) begin
          check_eq({p, " m_wdata"}, m_wdata_a[k], wdata);
          model_mem[k][addr[5:2]] = wdata;
        end else begin
          exp_q.push_back('{inst: k, due: cyc + k + 1, port: win, data: model_mem[k][addr[5:2]]});
        end
      end
      if (c_flush)
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].inst == k && exp_q[i].port == 0 && exp_q[i].due >= cyc) exp_q.delete(i);
      got[0] = 1'b0; got[1] = 1'b0; got[2] = 1'b0; gdat = 32'd0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].inst == k && exp_q[i].due == cyc) begin
          got[exp_q[i].port] = 1'b1;
          gdat = exp_q[i].data;
          exp_q.delete(i);
        end
      end
      check_eq({p, " f_rvalid"}, 32'(f_rvalid_v[k]), 32'(got[0]));
      check_eq({p, " d_rvalid"}, 32'(d_rvalid_v[k]), 32'(got[1]));
      check_eq({p, " g_rvalid"}, 32'(g_rvalid_v[k]), 32'(got[2]));
      if (got[0]) check_eq({p, " f_rdata"}, f_rdata_a[k], gdat);
      if (got[1]) check_eq({p, " d_rdata"}, d_rdata_a[k], gdat);
      if (got[2]) check_eq({p, " g_rdata"}, g_rdata_a[k], gdat);
      if (win == 0 || !f_req)  starve_m[k] = 0;
      else if (!g_halt)        starve_m[k] = (starve_m[k] < 15) ? starve_m[k] + 1 : 15;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rst = 1'b0; f_req = 1'b0; c_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
    g_req = 1'b0; g_we = 1'b0; g_halt = 1'b0;
    f_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; g_addr = 32'd0; g_wdata = 32'd0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic rand_inputs();
    rst     = ($urandom_range(0, 99) < 2);
    f_req   = ($urandom_range(0, 99) < 70);
    d_req   = ($urandom_range(0, 99) < 50);
    g_req   = ($urandom_range(0, 99) < 20);
    d_we    = $urandom_range(0, 1) == 1;
    g_we    = $urandom_range(0, 1) == 1;
    g_halt  = ($urandom_range(0, 99) < 15);
    c_flush = ($urandom_range(0, 99) < 10);
    f_addr  = $urandom;
    d_addr  = $urandom;
    g_addr  = $urandom;
    d_wdata = $urandom;
    g_wdata = $urandom;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      starve_m[k] = 0;
      for (int i = 0; i < 16; i++) model_mem[k][i] = init_word(i);
    end
    set_idle();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    // fetch-only read of 0x10
    f_req = 1'b1; f_addr = 32'h0000_0010;
    step(1);
    set_idle(); step(3);
    // load-store write then read back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    step(1);
    d_we = 1'b0;
    step(1);
    set_idle(); step(3);
    // all three requesting, then debug drops
    g_req = 1'b1; d_req = 1'b1; f_req = 1'b1; g_addr = 32'h8; d_addr = 32'h24; f_addr = 32'h30;
    step(12);
    g_req = 1'b0;
    step(4);
    set_idle(); step(3);
    // halt blocks fetch
    g_halt = 1'b1; f_req = 1'b1; f_addr = 32'h14;
    step(20);
    g_halt = 1'b0;
    step(2);
    set_idle(); step(3);
    // flush kills in-flight fetches
    f_req = 1'b1; f_addr = 32'h18;
    step(1);
    c_flush = 1'b1; f_addr = 32'h1C;
    step(1);
    set_idle(); step(4);
    // reset right after a read grant
    d_req = 1'b1; d_addr = 32'h4;
    step(1);
    set_idle(); rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      step(1);
    end
    set_idle(); step(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
